// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder datapath: default field widths,
// the normaliser case select and a constant-foldable clog2.
package fp_pkg;

  localparam int SP_EXP_W = 8;
  localparam int SP_MAN_W = 24;
  localparam int DP_EXP_W = 11;
  localparam int DP_MAN_W = 53;

  typedef enum logic [1:0] {
    CARRY,
    ZERO,
    SUBN,
    LEFT
  } norm_sel_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter, log-depth: halves the search window at each level.
// An all-zero input yields a count of W.
module fp_lzc
  import fp_pkg::*;
#(
  parameter int W  = 26,
  parameter int CW = clog2(W + 1)
) (
  input  logic [W-1:0]  i_vec,
  output logic [CW-1:0] o_cnt,
  output logic          o_zero
);

  localparam int P = 1 << CW;

  logic [P-1:0] w_v;

  // Ones below the LSB stop the search, so an all-zero input counts exactly W.
  always_comb begin
    o_cnt = '0;
    w_v   = {i_vec, {(P - W){1'b1}}};
    for (int s = CW - 1; s >= 0; s--) begin
      if ((w_v >> (P - (1 << s))) == '0) begin
        o_cnt[s] = 1'b1;
        w_v      = w_v << (1 << s);
      end
    end
  end

  assign o_zero = ~|i_vec;

endmodule

// File: rtl/fp_normalize_pipe.sv
// Two-stage post-add normaliser: carry right-shift, leading-zero left shift with
// gradual underflow, zero detect and optional infinity saturation, valid/ready pipelined.
module fp_normalize_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W   = SP_EXP_W,
  parameter int MAN_W   = SP_MAN_W,
  parameter bit SAT_INF = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W:0]   Mr,
  input  logic [EXP_W-1:0] Er,
  input  logic [2:0]       GRS,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] Mr_norm,
  output logic [EXP_W-1:0] Er_norm,
  output logic [2:0]       GRS_norm,
  output logic             overflow,
  output logic             underflow,
  output logic             zero
);

  localparam int WW  = MAN_W + 2;
  localparam int LZW = clog2(MAN_W + 3);
  localparam int XW  = EXP_W + 1;

  logic w_adv1, w_adv2;
  logic [WW-1:0]  w_vec_in;
  logic [LZW-1:0] w_lz_in;
  logic           w_zero_in;
  norm_sel_e      w_sel_in;

  logic             r_s1_valid;
  logic [MAN_W:0]   r_s1_mr;
  logic [EXP_W-1:0] r_s1_er;
  logic [2:0]       r_s1_grs;
  logic [LZW-1:0]   r_s1_lz;
  norm_sel_e        r_s1_sel;

  logic             r_out_valid;
  logic [MAN_W-1:0] r_mr_norm;
  logic [EXP_W-1:0] r_er_norm;
  logic [2:0]       r_grs_norm;
  logic             r_ovf, r_unf, r_zero;

  assign w_adv2   = out_ready | ~r_out_valid;
  assign w_adv1   = w_adv2 | ~r_s1_valid;
  assign in_ready = w_adv1;

  assign w_vec_in = {Mr[MAN_W-1:0], GRS[2], GRS[1]};

  fp_lzc #(.W(WW), .CW(LZW)) u_lzc (
    .i_vec  (w_vec_in),
    .o_cnt  (w_lz_in),
    .o_zero (w_zero_in)
  );

  always_comb begin
    if (Mr[MAN_W])         w_sel_in = CARRY;
    else if (w_zero_in)    w_sel_in = ZERO;
    else if (Er == '0)     w_sel_in = SUBN;
    else                   w_sel_in = LEFT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mr    <= '0;
      r_s1_er    <= '0;
      r_s1_grs   <= '0;
      r_s1_lz    <= '0;
      r_s1_sel   <= CARRY;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      r_s1_mr    <= Mr;
      r_s1_er    <= Er;
      r_s1_grs   <= GRS;
      r_s1_lz    <= w_lz_in;
      r_s1_sel   <= w_sel_in;
    end
  end

  logic [WW-1:0]    w_s1_vec, w_ws;
  logic [XW-1:0]    w_er_x, w_er_eff, w_er_inc;
  logic [EXP_W-1:0] w_er_sub;
  logic [LZW-1:0]   w_k;
  logic             w_lz_lt, w_carry_ovf;

  logic [MAN_W-1:0] w_mr_n;
  logic [EXP_W-1:0] w_er_n;
  logic [2:0]       w_grs_n;
  logic             w_ovf_n, w_unf_n, w_zero_n;

  assign w_s1_vec    = {r_s1_mr[MAN_W-1:0], r_s1_grs[2], r_s1_grs[1]};
  assign w_er_x      = {1'b0, r_s1_er};
  assign w_lz_lt     = XW'(r_s1_lz) < w_er_x;
  // When the shift would take the exponent below 1, stop at Er-1 and encode as subnormal.
  assign w_k         = w_lz_lt ? r_s1_lz : LZW'(r_s1_er - EXP_W'(1));
  assign w_ws        = w_s1_vec << w_k;
  assign w_er_sub    = r_s1_er - EXP_W'(r_s1_lz);
  assign w_er_eff    = (r_s1_er == '0) ? XW'(1) : w_er_x;
  assign w_er_inc    = w_er_eff + XW'(1);
  assign w_carry_ovf = w_er_inc >= {1'b0, {EXP_W{1'b1}}};

  always_comb begin
    w_mr_n   = '0;
    w_er_n   = '0;
    w_grs_n  = '0;
    w_ovf_n  = 1'b0;
    w_unf_n  = 1'b0;
    w_zero_n = 1'b0;
    case (r_s1_sel)
      CARRY: begin
        w_mr_n  = r_s1_mr[MAN_W:1];
        w_grs_n = {r_s1_mr[0], r_s1_grs[2], r_s1_grs[1] | r_s1_grs[0]};
        w_er_n  = w_er_inc[EXP_W-1:0];
        w_ovf_n = w_carry_ovf;
        if (SAT_INF && w_carry_ovf) begin
          w_mr_n  = '0;
          w_grs_n = '0;
          w_er_n  = '1;
        end
      end
      ZERO: begin
        w_grs_n  = {2'b00, r_s1_grs[0]};
        w_zero_n = 1'b1;
      end
      SUBN: begin
        w_mr_n  = r_s1_mr[MAN_W-1:0];
        w_grs_n = r_s1_grs;
        w_er_n  = {{(EXP_W-1){1'b0}}, r_s1_mr[MAN_W-1]};
      end
      LEFT: begin
        w_mr_n  = w_ws[WW-1:2];
        w_grs_n = {w_ws[1], w_ws[0], r_s1_grs[0]};
        w_er_n  = w_lz_lt ? w_er_sub : '0;
        w_unf_n = ~w_lz_lt & (w_k != '0);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_mr_norm   <= '0;
      r_er_norm   <= '0;
      r_grs_norm  <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      r_mr_norm   <= w_mr_n;
      r_er_norm   <= w_er_n;
      r_grs_norm  <= w_grs_n;
      r_ovf       <= r_s1_valid & w_ovf_n;
      r_unf       <= r_s1_valid & w_unf_n;
      r_zero      <= r_s1_valid & w_zero_n;
    end
  end

  assign out_valid = r_out_valid;
  assign Mr_norm   = r_mr_norm;
  assign Er_norm   = r_er_norm;
  assign GRS_norm  = r_grs_norm;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Scoreboard bench for fp_normalize_pipe (single precision, saturating): directed
// vectors with hand-computed results, backpressure hold and mid-stream reset.
module tb_fp_normalize_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] Mr;
  logic [7:0]  Er;
  logic [2:0]  GRS;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] Mr_norm;
  logic [7:0]  Er_norm;
  logic [2:0]  GRS_norm;
  logic        overflow, underflow, zero;

  fp_normalize_pipe #(.EXP_W(8), .MAN_W(24), .SAT_INF(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Mr        (Mr),
    .Er        (Er),
    .GRS       (GRS),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Mr_norm   (Mr_norm),
    .Er_norm   (Er_norm),
    .GRS_norm  (GRS_norm),
    .overflow  (overflow),
    .underflow (underflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [37:0] v;
    logic        chk_lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  logic [37:0] w_act;
  assign w_act = {Mr_norm, Er_norm, GRS_norm, overflow, underflow, zero};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [37:0] pk(input logic [23:0] m, input logic [7:0] e,
                                     input logic [2:0] g, input logic o,
                                     input logic u, input logic z);
    return {m, e, g, o, u, z};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  // Monitor: pops on every accepted output, checks hold while stalled.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got %0h, want no output", w_act);
      end else if (out_ready === 1'b1) begin
        mon_e = exp_q.pop_front();
        chk(mon_e.name, 64'(w_act), 64'(mon_e.v));
        if (mon_e.chk_lat) chk({mon_e.name, "_latency"}, 64'(cyc - mon_e.acc), 64'd2);
      end else begin
        chk({exp_q[0].name, "_hold"}, 64'(w_act), 64'(exp_q[0].v));
      end
    end
  end

  task automatic send(input string nm, input logic [24:0] mr, input logic [7:0] er,
                      input logic [2:0] grs, input logic [37:0] ex, input logic lat);
    int   g;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    Mr       = mr;
    Er       = er;
    GRS      = grs;
    g        = 0;
    while (in_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_accept: in_ready stuck at %b, want 1", nm, in_ready);
      in_valid = 1'b0;
      return;
    end
    e.name    = nm;
    e.v       = ex;
    e.chk_lat = lat;
    e.acc     = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk({nm, "_drain"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Mr        = '0;
    Er        = '0;
    GRS       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'(w_act), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    send("carry",      25'h1800000, 8'h80, 3'b101, pk(24'hC00000, 8'h81, 3'b011, 0, 0, 0), 1'b1);
    send("overflow",   25'h1000001, 8'hFE, 3'b000, pk(24'h000000, 8'hFF, 3'b000, 1, 0, 0), 1'b1);
    send("cancel",     25'h0000100, 8'h20, 3'b000, pk(24'h800000, 8'h11, 3'b000, 0, 0, 0), 1'b1);
    send("underflow",  25'h0000100, 8'h05, 3'b000, pk(24'h001000, 8'h00, 3'b000, 0, 1, 0), 1'b1);
    send("zero",       25'h0000000, 8'h40, 3'b001, pk(24'h000000, 8'h00, 3'b001, 0, 0, 1), 1'b1);
    send("subn_promo", 25'h0800000, 8'h00, 3'b000, pk(24'h800000, 8'h01, 3'b000, 0, 0, 0), 1'b1);
    send("subn_stay",  25'h0000100, 8'h00, 3'b010, pk(24'h000100, 8'h00, 3'b010, 0, 0, 0), 1'b1);
    send("pass_k0",    25'h0C00000, 8'h10, 3'b110, pk(24'hC00000, 8'h10, 3'b110, 0, 0, 0), 1'b1);
    send("shift_grs",  25'h0400000, 8'h80, 3'b011, pk(24'h800000, 8'h7F, 3'b101, 0, 0, 0), 1'b1);
    send("er1_noshift",25'h0400000, 8'h01, 3'b000, pk(24'h400000, 8'h00, 3'b000, 0, 0, 0), 1'b1);
    send("carry_er0",  25'h1000000, 8'h00, 3'b000, pk(24'h800000, 8'h02, 3'b000, 0, 0, 0), 1'b1);
    drain("directed");

    @(posedge clk);
    #2 out_ready = 1'b0;
    send("stall_a", 25'h0000100, 8'h20, 3'b000, pk(24'h800000, 8'h11, 3'b000, 0, 0, 0), 1'b0);
    send("stall_b", 25'h1800000, 8'h80, 3'b101, pk(24'hC00000, 8'h81, 3'b011, 0, 0, 0), 1'b0);
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    chk("stall_in_ready_held", 64'(in_ready), 64'd0);
    fork
      send("stall_c", 25'h0800000, 8'h00, 3'b000, pk(24'h800000, 8'h01, 3'b000, 0, 0, 0), 1'b1);
      begin
        @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain("stall");

    send("pre_reset", 25'h0000100, 8'h05, 3'b000, pk(24'h001000, 8'h00, 3'b000, 0, 1, 0), 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_outputs", 64'(w_act), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("post_reset_out_valid", 64'(out_valid), 64'd0);
    send("recover", 25'h0000100, 8'h05, 3'b000, pk(24'h001000, 8'h00, 3'b000, 0, 1, 0), 1'b1);
    drain("recover");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_normalize_pipe.md
Name: fp_normalize_pipe

Overview:
- Parametrised, two-stage pipelined post-add normaliser for the floating-point adder datapath. Sits between the significand add/subtract stage and the rounding stage.
- Extends the single-precision combinational normaliser in three ways:
  - right shift on carry-out;
  - full leading-zero left normalisation after cancellation, with gradual underflow into subnormals;
  - zero detect and optional infinity saturation on overflow.
- Uses a valid/ready handshake so the adder can be deeply pipelined and stalled.

Parameters:
- EXP_W, 8, exponent field width (11 for double).
- MAN_W, 24, significand width including hidden bit (53 for double).
- SAT_INF, 1, 1: on overflow drive Er_norm all-ones and Mr_norm zero; 0: pass the wrapped value, flag only.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage 1 can accept.
- Mr  in  MAN_W+1  raw significand, MSB = carry.
- Er  in  EXP_W  biased exponent before normalisation.
- GRS  in  3  guard, round, sticky.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- Mr_norm  out  MAN_W  normalised significand.
- Er_norm  out  EXP_W  normalised exponent.
- GRS_norm  out  3  adjusted guard/round/sticky.
- overflow  out  1  exponent reached all-ones.
- underflow  out  1  result is subnormal and was left-shifted (tiny).
- zero  out  1  significand, G and R all zero.

Behaviour:
- Reset: on a rising edge with rst_n=0, all pipeline valids and all outputs clear to 0; in_ready=1 on the following cycle. Reset mid-operation discards in-flight beats.
- Handshake:
  - A transfer occurs when valid and ready are both 1.
  - Latency is 2 cycles from input acceptance to out_valid with no stalls; throughput is 1 per cycle.
  - Stage advance: adv2 = out_ready or !out_valid; adv1 = adv2 or !s1_valid; in_ready = adv1.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
- Stage 1 (register):
  - Register the inputs.
  - Compute lz = leading-zero count of the (MAN_W+2)-bit vector W = {Mr[MAN_W-1:0], GRS[2], GRS[1]}.
  - Compute the case select: CARRY, SUBN, LEFT, ZERO.
- Stage 2 (register), case rules in priority order:
  - CARRY, when Mr[MAN_W]=1:
    - Mr_norm = Mr[MAN_W:1].
    - GRS_norm = {Mr[0], G, R|S}.
    - Er_norm = Er+1, using effective Er = max(Er,1).
    - If Er+1 equals all-ones: overflow=1 and, when SAT_INF=1, Mr_norm=0 and GRS_norm=0.
  - ZERO, when W==0: Er_norm=0, Mr_norm=0, GRS_norm={0,0,S}, zero=1.
  - SUBN, when Er==0:
    - No shift: Mr_norm=Mr[MAN_W-1:0], GRS_norm=GRS.
    - Er_norm=1 if Mr[MAN_W-1]=1 (subnormal promoted to normal), else 0.
  - LEFT, otherwise:
    - k = lz if lz < Er, else Er-1.
    - Ws = W << k, zero-filled.
    - Mr_norm = Ws[MAN_W+1:2]; GRS_norm = {Ws[1], Ws[0], S}.
    - Er_norm = Er-k if lz < Er, else 0, and underflow=1 when Er_norm=0 and k > 0.
    - k=0 is a pass-through.
- Width rules:
  - lz and k are clog2(MAN_W+3) bits wide.
  - Exponent arithmetic uses EXP_W+1 bits internally; no wrap is visible except through overflow when SAT_INF=0.
- overflow, underflow and zero are mutually exclusive and valid only with out_valid; they are 0 otherwise.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W and MAN_W defaults for SP and DP;
  - the case-select enum {CARRY, ZERO, SUBN, LEFT};
  - the function clog2.
- One natural sub-module, fp_lzc: parametrised leading-zero counter, combinational tree, width MAN_W+2, outputs count and all-zero.

Test Plan:
- Carry: Mr=25'h1800000, Er=8'h80, GRS=3'b101 -> 2 cycles later Mr_norm=24'hC00000, Er_norm=8'h81, GRS_norm=3'b011, flags 0.
- Overflow: Mr=25'h1000001, Er=8'hFE, SAT_INF=1 -> Er_norm=8'hFF, Mr_norm=0, GRS_norm=0, overflow=1.
- Cancellation: Mr=25'h0000100, Er=8'h20, GRS=0 -> lz=15, Mr_norm=24'h800000, Er_norm=8'h11, flags 0.
- Gradual underflow: Mr=25'h0000100, Er=8'h05, GRS=0 -> k=4, Mr_norm=24'h001000, Er_norm=0, underflow=1.
- Zero and subnormal promotion:
  - Mr=0, Er=8'h40, GRS=3'b001 -> zero=1, Er_norm=0, GRS_norm=3'b001.
  - Mr=25'h0800000, Er=0 -> Er_norm=1.
- Backpressure and reset:
  - Feed 3 back-to-back beats with out_ready=0 -> in_ready drops after 2 accepted, outputs hold; raise out_ready -> beats emerge in order.
  - Assert rst_n=0 mid-stream -> next edge out_valid=0, in_ready=1 after release.
